// File: rtl/deadtime_gate_drv.sv
// rtl/deadtime_gate_drv.sv - half-bridge gate driver with per-edge dead time, fault latch and switch counter
// Optional macro FAULT_DEGLITCH_EN: fault_in must be high on 3 consecutive edges before it qualifies.
module deadtime_gate_drv #(
  parameter int DT_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             pwm_in,
  input  logic [DT_W-1:0]  dt_lh,
  input  logic [DT_W-1:0]  dt_hl,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic             gate_hi,
  output logic             gate_lo,
  output logic             fault_latched,
  output logic [CNT_W-1:0] sw_cnt
);

`ifdef FAULT_DEGLITCH_EN
  localparam logic [1:0] FLT_RUN = 2'd3;
`else
  localparam logic [1:0] FLT_RUN = 2'd1;
`endif

  typedef enum logic [2:0] {
    OFF,
    DT_TO_LO,
    LO_ON,
    DT_TO_HI,
    HI_ON,
    FAULT
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [DT_W-1:0] dt_cnt;
  logic [DT_W-1:0] dt_nxt;
  logic [1:0]      flt_run;
  logic            flt_q;
  logic            dt_done;

  // Fault qualifies once the consecutive-sample run reaches its threshold.
  assign flt_q   = (flt_run == FLT_RUN);
  // A loaded count of 0 behaves like 1: a dead-time phase always lasts at least one cycle.
  assign dt_done = (dt_cnt <= DT_W'(1));

  always_comb begin
    nxt    = state;
    dt_nxt = dt_cnt;
    if (flt_q) begin
      nxt = FAULT;
    end else if (state == FAULT) begin
      if (fault_clr && !fault_in) nxt = OFF;
    end else if (!en) begin
      nxt = OFF;
    end else begin
      case (state)
        OFF:      nxt = pwm_in ? DT_TO_HI : DT_TO_LO;
        LO_ON:    if (pwm_in) nxt = DT_TO_HI;
        HI_ON:    if (!pwm_in) nxt = DT_TO_LO;
        DT_TO_HI: begin
          if (!pwm_in)      nxt = LO_ON;
          else if (dt_done) nxt = HI_ON;
          else              dt_nxt = dt_cnt - 1'b1;
        end
        DT_TO_LO: begin
          if (pwm_in)       nxt = HI_ON;
          else if (dt_done) nxt = LO_ON;
          else              dt_nxt = dt_cnt - 1'b1;
        end
        default:  nxt = OFF;
      endcase
    end
    // Dead time is captured only on entry; later dt_* changes do not disturb a running phase.
    if (nxt == DT_TO_HI && state != DT_TO_HI) dt_nxt = dt_lh;
    if (nxt == DT_TO_LO && state != DT_TO_LO) dt_nxt = dt_hl;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= OFF;
      dt_cnt        <= '0;
      flt_run       <= '0;
      gate_hi       <= 1'b0;
      gate_lo       <= 1'b0;
      fault_latched <= 1'b0;
      sw_cnt        <= '0;
    end else begin
      state         <= nxt;
      dt_cnt        <= dt_nxt;
      gate_hi       <= (nxt == HI_ON);
      gate_lo       <= (nxt == LO_ON);
      fault_latched <= (nxt == FAULT);
      if (nxt == HI_ON && state != HI_ON) sw_cnt <= sw_cnt + 1'b1;
      if (!fault_in)               flt_run <= '0;
      else if (flt_run != FLT_RUN) flt_run <= flt_run + 1'b1;
    end
  end

endmodule
